position_update_controller: RTL
===============================

# position_update_controller

Frame-synchronous scheduler that owns the player and car positions consumed by the VGA sprite renderer. It captures single-cycle direction pulses and, once per frame at the start of vertical blanking, sequences a fixed update pipeline: player move with edge clamping, car advance with wrap-around, and collision check. It then commits all four positions atomically, so the renderer never sees a torn update mid-frame.

## Interface
Parameters:
- TILE_SIZE, 16, sprite edge and player step in pixels
- H_VISIBLE_AREA, 640, visible width
- V_VISIBLE_AREA, 480, visible height
- PLAYER_START_X, 312, player X after reset or collision
- PLAYER_START_Y, 464, player Y after reset or collision
- CAR_START_X, 0, car X after reset
- CAR_Y, 240, fixed car lane Y
- CAR_SPEED, 2, car pixels per step; must be 1..TILE_SIZE
- CAR_DIV, 1, frames per car step; must be ≥1

Ports:
- i_Clk  in  1  pixel clock; the only clock
- i_Rst_L  in  1  reset, synchronous, active-low
- i_Frame_Start  in  1  one-cycle pulse at the first blanking line
- i_Up / i_Down / i_Left / i_Right  in  1 each  debounced one-cycle move requests
- o_Player_X / o_Player_Y  out  10  committed player position
- o_Car_X / o_Car_Y  out  10  committed car position
- o_Collision  out  1  one-cycle pulse when a collision was resolved
- o_Busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Pending move register holds 1 slot (valid plus 2-bit direction).
- A direction pulse loads the slot only when the slot is empty. Later presses are dropped until the slot is consumed.
- Same-cycle multiple pulses resolve by priority: Up > Down > Left > Right.
- A pulse in the same cycle that PLAYER consumes the slot is captured as the new pending move.
- FSM states: IDLE → PLAYER → CAR → CHECK → COMMIT → IDLE.
- IDLE: leaves on i_Frame_Start. i_Frame_Start outside IDLE is ignored; no queueing.
- PLAYER: the shadow player position applies the pending move. Moves are computed in 11 bits.
  - Up: Y ≥ TILE_SIZE ? Y−TILE_SIZE : 0.
  - Down: Y+2·TILE_SIZE ≤ V_VISIBLE_AREA ? Y+TILE_SIZE : V_VISIBLE_AREA−TILE_SIZE.
  - Left and Right: same rules against X and H_VISIBLE_AREA.
  - No pending move: position unchanged.
- CAR: the frame divider increments. When it reaches CAR_DIV−1, it clears and the car steps.
  - Step: X+CAR_SPEED > H_VISIBLE_AREA−TILE_SIZE ? 0 : X+CAR_SPEED.
- CHECK: AABB overlap of the new shadows (px<cx+T ∧ cx<px+T ∧ py<cy+T ∧ cy<py+T, in 11 bits).
  - Overlap forces the shadow player to PLAYER_START_X/Y and sets the internal collision flag.
- COMMIT: all four outputs load from the shadows on the same edge. o_Collision pulses if the flag is set, then the flag clears.
- o_Car_Y is constant at CAR_Y.

## Timing
- Reset values: o_Player_X=PLAYER_START_X, o_Player_Y=PLAYER_START_Y, o_Car_X=CAR_START_X, o_Car_Y=CAR_Y, o_Collision=0, o_Busy=0.
- Reset also clears the pending slot, the divider, the collision flag and the shadows (to start values). The FSM returns to IDLE.
- Reset mid-sequence aborts the sequence with no partial commit.
- Latency: i_Frame_Start sampled at edge N.
  - FSM in PLAYER after edge N; o_Busy high from N.
  - Outputs and o_Collision update at edge N+4.
  - o_Busy low after edge N+4.
- o_Collision is high exactly 1 cycle, coincident with the first cycle of the new positions.
- Outputs are stable for all other cycles. A frame update occupies 4 cycles, well inside blanking.

## Structure
- Shared package (constants include shared with the sprite renderer):
  - TILE_SIZE, H_VISIBLE_AREA, V_VISIBLE_AREA
  - direction encoding (UP=0, DOWN=1, LEFT=2, RIGHT=3)
  - FSM state encoding
- One sub-module is natural: `tile_overlap`, the combinational AABB comparator taking two 10-bit XY pairs and TILE_SIZE. The renderer-side hit tests can reuse it.
- Everything else lives in this module: capture logic, FSM, clamp/wrap arithmetic, shadow and output registers.

## Test plan
- Reset, then hold 10 cycles → outputs (312,464), car (0,240); o_Collision=0, o_Busy=0.
- i_Up, then i_Frame_Start → 4 cycles later player (312,448). o_Busy high for exactly 4 cycles; car X=2.
- Player at Y=464, i_Down + frame → Y stays 464. Player at X=0, i_Left → X stays 0. Two presses before one frame → only the first is applied.
- Car at X=622, CAR_SPEED=2, one frame → X=624 (= 640−16). Next frame → X=0 (622+2≤624 steps to 624; 624+2>624 wraps to 0).
- Car placed to overlap after the move (player (312,256)→Up→(312,240), car X=310) → commit shows player (312,464). o_Collision is a one-cycle pulse aligned with the commit.
- i_Frame_Start asserted during PLAYER → ignored, single commit. i_Rst_L low during CHECK → outputs return to reset values with no commit pulse.

Source files
------------

// File: rtl/position_update_controller_pkg.sv
// ----------------------------------------------------------------------------
// position_update_controller_pkg
// Constants and encodings shared by the position update controller and the
// VGA sprite renderer: screen and tile geometry, move direction encoding,
// scheduler state encoding and the pending-move slot payload.
// ----------------------------------------------------------------------------
package position_update_controller_pkg;

    localparam int unsigned TILE_SIZE      = 16;
    localparam int unsigned H_VISIBLE_AREA = 640;
    localparam int unsigned V_VISIBLE_AREA = 480;

    // Committed coordinates are 10 bits; arithmetic uses one extra bit so
    // that sums near the screen edge cannot wrap before they are compared.
    localparam int unsigned POS_W  = 10;
    localparam int unsigned CALC_W = 11;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAYER = 3'd1,
        ST_CAR    = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    typedef struct packed {
        logic valid;
        dir_e dir;
    } move_slot_t;

    // Same-cycle requests resolve Up > Down > Left > Right; Right is the
    // fall-through, so callers gate the result with "any request present".
    function automatic dir_e pick_dir(input logic up, input logic down,
                                      input logic left);
        dir_e d;
        if (up)        d = DIR_UP;
        else if (down) d = DIR_DOWN;
        else if (left) d = DIR_LEFT;
        else           d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/tile_overlap.sv
// ----------------------------------------------------------------------------
// tile_overlap
// Combinational axis-aligned bounding-box test between two square tiles of
// edge TILE_SIZE whose top-left corners are (a_x,a_y) and (b_x,b_y).
//   a_x, a_y   in  10  top-left corner of tile A
//   b_x, b_y   in  10  top-left corner of tile B
//   overlap_c  out 1   high when the tiles share at least one pixel
// ----------------------------------------------------------------------------
module tile_overlap #(
    parameter int unsigned TILE_SIZE = position_update_controller_pkg::TILE_SIZE
) (
    input  logic [position_update_controller_pkg::POS_W-1:0] a_x,
    input  logic [position_update_controller_pkg::POS_W-1:0] a_y,
    input  logic [position_update_controller_pkg::POS_W-1:0] b_x,
    input  logic [position_update_controller_pkg::POS_W-1:0] b_y,
    output logic                                             overlap_c
);
    import position_update_controller_pkg::*;

    localparam logic [CALC_W-1:0] T_EXT = CALC_W'(TILE_SIZE);

    logic [CALC_W-1:0] ax, ay, bx, by;

    // Widened so that x + TILE_SIZE near the right/bottom edge stays exact.
    always_comb begin
        ax = CALC_W'(a_x);
        ay = CALC_W'(a_y);
        bx = CALC_W'(b_x);
        by = CALC_W'(b_y);
        overlap_c = (ax < bx + T_EXT) && (bx < ax + T_EXT) &&
                    (ay < by + T_EXT) && (by < ay + T_EXT);
    end

endmodule

// File: rtl/position_update_controller.sv
// ----------------------------------------------------------------------------
// position_update_controller
// Once per frame (on i_Frame_Start, first blanking line) applies the pending
// player move with edge clamping, advances the car with wrap-around, resolves
// a player/car collision and then commits all positions on a single edge so
// the renderer never sees a half-updated frame.
//   i_Clk          in  1   pixel clock
//   i_Rst_L        in  1   synchronous active-low reset
//   i_Frame_Start  in  1   one-cycle pulse at start of vertical blanking
//   i_Up/Down/Left/Right in 1 each  one-cycle move requests
//   o_Player_X/Y   out 10  committed player position
//   o_Car_X/Y      out 10  committed car position
//   o_Collision    out 1   one-cycle pulse with a commit that reset the player
//   o_Busy         out 1   high while a frame update is in progress
// CAR_SPEED must be 1..TILE_SIZE and CAR_DIV at least 1.
// ----------------------------------------------------------------------------
module position_update_controller #(
    parameter int unsigned TILE_SIZE      = position_update_controller_pkg::TILE_SIZE,
    parameter int unsigned H_VISIBLE_AREA = position_update_controller_pkg::H_VISIBLE_AREA,
    parameter int unsigned V_VISIBLE_AREA = position_update_controller_pkg::V_VISIBLE_AREA,
    parameter int unsigned PLAYER_START_X = 312,
    parameter int unsigned PLAYER_START_Y = 464,
    parameter int unsigned CAR_START_X    = 0,
    parameter int unsigned CAR_Y          = 240,
    parameter int unsigned CAR_SPEED      = 2,
    parameter int unsigned CAR_DIV        = 1
) (
    input  logic                                             i_Clk,
    input  logic                                             i_Rst_L,
    input  logic                                             i_Frame_Start,
    input  logic                                             i_Up,
    input  logic                                             i_Down,
    input  logic                                             i_Left,
    input  logic                                             i_Right,
    output logic [position_update_controller_pkg::POS_W-1:0] o_Player_X,
    output logic [position_update_controller_pkg::POS_W-1:0] o_Player_Y,
    output logic [position_update_controller_pkg::POS_W-1:0] o_Car_X,
    output logic [position_update_controller_pkg::POS_W-1:0] o_Car_Y,
    output logic                                             o_Collision,
    output logic                                             o_Busy
);
    import position_update_controller_pkg::*;

    localparam logic [CALC_W-1:0] T_EXT      = CALC_W'(TILE_SIZE);
    localparam logic [CALC_W-1:0] T2_EXT     = CALC_W'(2 * TILE_SIZE);
    localparam logic [CALC_W-1:0] H_EXT      = CALC_W'(H_VISIBLE_AREA);
    localparam logic [CALC_W-1:0] V_EXT      = CALC_W'(V_VISIBLE_AREA);
    localparam logic [CALC_W-1:0] SPEED_EXT  = CALC_W'(CAR_SPEED);
    localparam logic [CALC_W-1:0] CAR_LIMIT  = CALC_W'(H_VISIBLE_AREA - TILE_SIZE);

    localparam logic [POS_W-1:0] P_START_X = POS_W'(PLAYER_START_X);
    localparam logic [POS_W-1:0] P_START_Y = POS_W'(PLAYER_START_Y);
    localparam logic [POS_W-1:0] C_START_X = POS_W'(CAR_START_X);
    localparam logic [POS_W-1:0] C_LANE_Y  = POS_W'(CAR_Y);

    localparam int unsigned        DIV_W    = (CAR_DIV > 1) ? $clog2(CAR_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CAR_DIV - 1);

    state_e            state_q, state_d;
    move_slot_t        slot_q;
    logic [POS_W-1:0]  sh_px, sh_py, sh_cx;
    logic [DIV_W-1:0]  div_q;
    logic              coll_flag_q;

    logic              pulse_any_c;
    dir_e              pulse_dir_c;
    logic [POS_W-1:0]  move_x_c, move_y_c;
    logic [POS_W-1:0]  car_step_c;
    logic              hit_c;

    // Request decode with fixed priority.
    always_comb begin
        pulse_any_c = i_Up | i_Down | i_Left | i_Right;
        pulse_dir_c = pick_dir(i_Up, i_Down, i_Left);
    end

    // Single-slot pending move: loads only when empty, except that the cycle
    // which consumes it may immediately refill it with a fresh request.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            slot_q <= '{valid: 1'b0, dir: DIR_UP};
        end else if (state_q == ST_PLAYER) begin
            slot_q.valid <= pulse_any_c;
            if (pulse_any_c) slot_q.dir <= pulse_dir_c;
        end else if (!slot_q.valid && pulse_any_c) begin
            slot_q.valid <= 1'b1;
            slot_q.dir   <= pulse_dir_c;
        end
    end

    // State register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: fixed sequence; frame starts outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_Frame_Start) state_d = ST_PLAYER;
            ST_PLAYER: state_d = ST_CAR;
            ST_CAR:    state_d = ST_CHECK;
            ST_CHECK:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Player move with clamping so the tile stays fully on screen.
    always_comb begin
        logic [CALC_W-1:0] px, py;
        px       = CALC_W'(sh_px);
        py       = CALC_W'(sh_py);
        move_x_c = sh_px;
        move_y_c = sh_py;
        if (slot_q.valid) begin
            case (slot_q.dir)
                DIR_UP:    move_y_c = (py >= T_EXT) ? POS_W'(py - T_EXT) : '0;
                DIR_DOWN:  move_y_c = (py + T2_EXT <= V_EXT) ? POS_W'(py + T_EXT)
                                                             : POS_W'(V_EXT - T_EXT);
                DIR_LEFT:  move_x_c = (px >= T_EXT) ? POS_W'(px - T_EXT) : '0;
                DIR_RIGHT: move_x_c = (px + T2_EXT <= H_EXT) ? POS_W'(px + T_EXT)
                                                             : POS_W'(H_EXT - T_EXT);
                default:   move_x_c = sh_px;
            endcase
        end
    end

    // Car step wraps to the left edge once it would pass the last full tile.
    always_comb begin
        logic [CALC_W-1:0] cx_next;
        cx_next    = CALC_W'(sh_cx) + SPEED_EXT;
        car_step_c = (cx_next > CAR_LIMIT) ? '0 : POS_W'(cx_next);
    end

    tile_overlap #(
        .TILE_SIZE (TILE_SIZE)
    ) u_tile_overlap (
        .a_x       (sh_px),
        .a_y       (sh_py),
        .b_x       (sh_cx),
        .b_y       (C_LANE_Y),
        .overlap_c (hit_c)
    );

    // Shadow pipeline and atomic commit of all outputs.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sh_px       <= P_START_X;
            sh_py       <= P_START_Y;
            sh_cx       <= C_START_X;
            div_q       <= '0;
            coll_flag_q <= 1'b0;
            o_Player_X  <= P_START_X;
            o_Player_Y  <= P_START_Y;
            o_Car_X     <= C_START_X;
            o_Car_Y     <= C_LANE_Y;
            o_Collision <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            case (state_q)
                ST_PLAYER: begin
                    sh_px <= move_x_c;
                    sh_py <= move_y_c;
                end
                ST_CAR: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        sh_cx <= car_step_c;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (hit_c) begin
                        sh_px       <= P_START_X;
                        sh_py       <= P_START_Y;
                        coll_flag_q <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    o_Player_X  <= sh_px;
                    o_Player_Y  <= sh_py;
                    o_Car_X     <= sh_cx;
                    o_Car_Y     <= C_LANE_Y;
                    coll_flag_q <= 1'b0;
                end
                default: ;
            endcase
            o_Collision <= (state_q == ST_COMMIT) && coll_flag_q;
            o_Busy      <= (state_d != ST_IDLE);
        end
    end

endmodule
